// File: rtl/bcd_to_binary_seq_pkg.sv
// ============================================================================
// Module : bcd_pkg
// Shared state encoding and digit-correction constants for bcd_to_binary_seq.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int BCD_MAX_DIGIT = 9;
  localparam int CORR_THRESH   = 8;
  localparam int CORR_VAL      = 3;

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_to_binary_seq_if.sv
// ============================================================================
// Module : bcd_to_binary_seq_if
// Start/busy/done request and result bundle for the BCD-to-binary converter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface bcd_to_binary_seq_if #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) ();

  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic [BIN_W-1:0]      bin_out;
  logic                  err;

  modport master (
    output start, bcd_in,
    input  busy, done, bin_out, err
  );

  modport slave (
    input  start, bcd_in,
    output busy, done, bin_out, err
  );

endinterface

`default_nettype wire

// File: rtl/bcd_to_binary_seq_sub3.sv
// ============================================================================
// Module : bcd_sub3
// Per-digit correction for reverse double-dabble: subtract 3 when digit >= 8.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_sub3
  import bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'(CORR_THRESH)) ? (digit_i - 4'(CORR_VAL)) : digit_i;

endmodule

`default_nettype wire

// File: rtl/bcd_to_binary_seq.sv
// ============================================================================
// Module : bcd_to_binary_seq
// Iterative BCD-to-binary converter (reverse double-dabble) with handshake.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_to_binary_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  bcd_to_binary_seq_if.slave bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  if ((64'd1 << BIN_W) < pow10(DIGITS)) begin : g_width_check
    $error("bcd_to_binary_seq: BIN_W too narrow for DIGITS");
  end

  state_e             state_q, state_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   bin_out_q, bin_out_d;
  logic               err_q, err_d;

  logic [BCD_W-1:0]   bcd_sh;
  logic [BCD_W-1:0]   bcd_corr;
  logic [BIN_W-1:0]   bin_sh;
  logic               in_invalid;
  logic               last_iter;

  // The low BCD bit falls into the top of the binary accumulator
  assign bcd_sh    = {1'b0, bcd_q[BCD_W-1:1]};
  assign bin_sh    = {bcd_q[0], bin_q[BIN_W-1:1]};
  assign last_iter = (cnt_q == CNT_W'(BIN_W - 1));

  for (genvar g = 0; g < DIGITS; g++) begin : g_sub3
    bcd_sub3 u_sub3 (
      .digit_i (bcd_sh[4*g +: 4]),
      .digit_o (bcd_corr[4*g +: 4])
    );
  end

  always_comb begin
    in_invalid = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.bcd_in[4*i +: 4] > 4'(BCD_MAX_DIGIT)) in_invalid = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    bcd_d     = bcd_q;
    bin_d     = bin_q;
    cnt_d     = cnt_q;
    bin_out_d = bin_out_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (in_invalid) begin
            state_d   = ST_DONE;
            err_d     = 1'b1;
            bin_out_d = '0;
          end else begin
            state_d = ST_SHIFT;
            bcd_d   = bus.bcd_in;
            bin_d   = '0;
            cnt_d   = '0;
          end
        end
      end
      ST_SHIFT: begin
        bcd_d = bcd_corr;
        bin_d = bin_sh;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) begin
          bin_out_d = bin_sh;
          err_d     = 1'b0;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bcd_q     <= '0;
      bin_q     <= '0;
      cnt_q     <= '0;
      bin_out_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcd_q     <= bcd_d;
      bin_q     <= bin_d;
      cnt_q     <= cnt_d;
      bin_out_q <= bin_out_d;
      err_q     <= err_d;
    end
  end

  // Valid BCD must be fully drained into the binary side by the last iteration
  always @(posedge clk) begin
    if (rst_n && state_q == ST_SHIFT && last_iter) begin
      assert (bcd_corr == '0);
    end
  end

  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.done    = (state_q == ST_DONE);
  assign bus.bin_out = bin_out_q;
  assign bus.err     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_to_binary_seq.sv
// ============================================================================
// Module : tb_bcd_to_binary_seq
// Directed self-checking bench with a decimal-arithmetic reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bcd_to_binary_seq;

  typedef struct {
    int val;
    int err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   cyc;
  exp_t exp_q[$];
  int   last_bin;
  int   last_err;

  bcd_to_binary_seq_if #(.DIGITS(3), .BIN_W(10)) bif ();

  bcd_to_binary_seq #(.DIGITS(3), .BIN_W(10)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: decimal weight of each digit; any nibble above 9 flags an error
  function automatic exp_t model(input logic [11:0] b);
    exp_t e;
    logic [3:0] d;
    int w;
    e.val = 0;
    e.err = 0;
    w = 1;
    for (int i = 0; i < 3; i++) begin
      d = b[4*i +: 4];
      if (d > 4'd9) e.err = 1;
      e.val += int'(d) * w;
      w *= 10;
    end
    if (e.err != 0) e.val = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      last_bin = 0;
      last_err = 0;
    end else if (bif.done) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got done=1 expected no completion (t=%0t)", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        last_bin = e.val;
        last_err = e.err;
        check("bin_out", int'(bif.bin_out), e.val);
        check("err", int'(bif.err), e.err);
      end
    end else begin
      check("hold_bin_out", int'(bif.bin_out), last_bin);
      check("hold_err", int'(bif.err), last_err);
    end
  end

  // Wait (bounded) for done, sampling 1 time unit after each rising edge
  task automatic wait_done(output int n, output int busy_n);
    n = 0;
    busy_n = 0;
    while (!bif.done && n < 40) begin
      if (bif.busy) busy_n++;
      @(posedge clk); #1;
      n++;
    end
    if (bif.busy) busy_n++;
  endtask

  task automatic convert(input logic [11:0] bcd, input int exp_lat);
    int n;
    int busy_n;
    @(negedge clk);
    bif.start  = 1'b1;
    bif.bcd_in = bcd;
    exp_q.push_back(model(bcd));
    @(posedge clk); #1;
    bif.start  = 1'b0;
    bif.bcd_in = 12'($urandom);
    wait_done(n, busy_n);
    check("latency", n, exp_lat);
    check("busy_span", busy_n, exp_lat + 1);
    @(posedge clk); #1;
    check("done_pulse_width", int'(bif.done), 0);
    check("busy_after_done", int'(bif.busy), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, int'(bif.busy), 0);
    check({tag, "_done"}, int'(bif.done), 0);
    check({tag, "_bin_out"}, int'(bif.bin_out), 0);
    check({tag, "_err"}, int'(bif.err), 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int busy_n;
    int t[3];
    logic [11:0] b;
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    last_bin    = 0;
    last_err    = 0;
    rst_n       = 1'b0;
    bif.start   = 1'b0;
    bif.bcd_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1. all zeros, 10 shifts, busy for 11 cycles
    convert(12'h000, 10);
    check("lit_000", int'(bif.bin_out), 0);

    // 2/3. literal pins on the model and the DUT
    convert(12'h255, 10);
    check("lit_255", int'(bif.bin_out), 10'h0FF);
    convert(12'h999, 10);
    check("lit_999", int'(bif.bin_out), 10'h3E7);

    // 4. invalid middle digit, then a valid follow-up
    convert(12'h2A5, 0);
    check("lit_2A5_err", int'(bif.err), 1);
    check("lit_2A5_bin", int'(bif.bin_out), 0);
    convert(12'h017, 10);
    check("lit_017", int'(bif.bin_out), 17);
    check("lit_017_err", int'(bif.err), 0);
    convert(12'h00F, 0);
    check("lit_00F_err", int'(bif.err), 1);
    convert(12'hB00, 0);
    check("lit_B00_err", int'(bif.err), 1);

    // 5a. start while busy is ignored
    @(negedge clk);
    bif.start  = 1'b1;
    bif.bcd_in = 12'h123;
    exp_q.push_back(model(12'h123));
    @(negedge clk);
    bif.start = 1'b0;
    repeat (3) @(negedge clk);
    bif.start  = 1'b1;
    bif.bcd_in = 12'h456;
    @(negedge clk);
    bif.start = 1'b0;
    @(posedge clk); #1;
    wait_done(n, busy_n);
    check("lit_123", int'(bif.bin_out), 123);
    @(posedge clk); #1;
    check("ignored_start_idle", int'(bif.busy), 0);

    // 5b. start held high: back-to-back conversions every 12 cycles
    @(negedge clk);
    bif.start  = 1'b1;
    bif.bcd_in = 12'h456;
    for (int i = 0; i < 3; i++) exp_q.push_back(model(12'h456));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      wait_done(n, busy_n);
      t[i] = cyc;
      check("lit_456", int'(bif.bin_out), 456);
    end
    bif.start = 1'b0;
    check("b2b_period_1", t[1] - t[0], 12);
    check("b2b_period_2", t[2] - t[1], 12);
    repeat (2) @(posedge clk); #1;
    check("b2b_no_extra", int'(bif.busy), 0);

    // 6. reset mid-conversion
    @(negedge clk);
    bif.start  = 1'b1;
    bif.bcd_in = 12'h876;
    exp_q.push_back(model(12'h876));
    @(negedge clk);
    bif.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    convert(12'h001, 10);
    check("lit_001", int'(bif.bin_out), 1);

    // sweep every valid 3-digit value
    for (int v = 0; v < 1000; v++) begin
      b = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      convert(b, 10);
      check("sweep", int'(bif.bin_out), v);
    end

    repeat (2) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
